// File: rtl/ms_time_entry_pkg.sv
// Shared definitions for the MM:SS time-entry front end: key codes,
// controller states and the default quick-start time.
`timescale 1ns/1ps
package ms_time_entry_pkg;

  localparam logic [3:0]  KEY_CANCEL     = 4'd10;
  localparam logic [3:0]  KEY_START      = 4'd11;
  localparam logic [15:0] QUICK_TIME_DEF = 16'h0030;
  localparam int          MAX_DIGITS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_LOAD,
    ST_START,
    ST_RUN
  } state_e;

endpackage

// File: rtl/ms_time_entry_normalize.sv
// Folds an out-of-range seconds-tens digit into the minutes, so that
// MM:SS entries such as 00:90 become 01:30 and saturate at 99:59.
`timescale 1ns/1ps
module bcd_mmss_normalize (
  input  logic [15:0] bcd_i,
  output logic [15:0] bcd_o
);

  always_comb begin
    bcd_o = bcd_i;
    if (bcd_i[7:4] >= 4'd6) begin
      if (bcd_i[15:8] == 8'h99) begin
        bcd_o = 16'h9959;
      end else begin
        bcd_o[7:4] = bcd_i[7:4] - 4'd6;
        if (bcd_i[11:8] == 4'd9) begin
          bcd_o[11:8]  = 4'd0;
          bcd_o[15:12] = bcd_i[15:12] + 4'd1;
        end else begin
          bcd_o[11:8] = bcd_i[11:8] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ms_time_entry.sv
// Keypad-driven writer for the MS_Timer: collects up to four BCD digits,
// loads the normalised value with a one-cycle active-low strobe, then starts.
`timescale 1ns/1ps
import ms_time_entry_pkg::*;

module ms_time_entry #(
  parameter logic [15:0] QUICK_TIME = QUICK_TIME_DEF,
  parameter int          MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        timer_busy,
  input  logic        timer_zero,
  output logic [15:0] entry_digits,
  output logic [15:0] load_value,
  output logic        load_n,
  output logic        start,
  output logic        stop,
  output logic        err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_e      state_q, state_d;
  logic        key_valid_q;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] load_value_q, load_value_d;
  logic        load_n_q, load_n_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        err_q, err_d;
  logic        run_armed_q, run_armed_d;
  logic        press;
  logic        is_digit;
  logic [15:0] norm_value;

  assign press    = key_valid & ~key_valid_q;
  assign is_digit = (key_code <= 4'd9);

  bcd_mmss_normalize u_norm (
    .bcd_i (entry_q),
    .bcd_o (norm_value)
  );

  // Pulse outputs are registered alongside the state so they are glitch-free
  // and line up exactly with the LOAD/START/RUN transitions.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= ST_IDLE;
      key_valid_q  <= 1'b0;
      entry_q      <= '0;
      count_q      <= '0;
      load_value_q <= '0;
      load_n_q     <= 1'b1;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      err_q        <= 1'b0;
      run_armed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_valid_q  <= key_valid;
      entry_q      <= entry_d;
      count_q      <= count_d;
      load_value_q <= load_value_d;
      load_n_q     <= load_n_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      err_q        <= err_d;
      run_armed_q  <= run_armed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    count_d      = count_q;
    load_value_d = load_value_q;
    load_n_d     = 1'b1;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    err_d        = 1'b0;
    run_armed_d  = run_armed_q;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (press) begin
          if (is_digit) begin
            if (count_q < MAX_CNT) begin
              entry_d = {entry_q[11:0], key_code};
              count_d = count_q + 3'd1;
              state_d = ST_ENTRY;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_CANCEL) begin
            entry_d = '0;
            count_d = '0;
            state_d = ST_IDLE;
          end else if (key_code == KEY_START) begin
            if (timer_busy) begin
              err_d = 1'b1;
            end else begin
              load_value_d = (count_q == 3'd0) ? QUICK_TIME : norm_value;
              load_n_d     = 1'b0;
              state_d      = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        start_d = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        run_armed_d = 1'b0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // The first RUN cycle ignores timer_zero: the timer may not yet
        // have left its previous zero value.
        run_armed_d = 1'b1;
        if (press && key_code == KEY_CANCEL) begin
          stop_d  = 1'b1;
          entry_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          if (run_armed_q && timer_zero) begin
            entry_d = '0;
            count_d = '0;
            state_d = ST_IDLE;
          end
          if (press && (is_digit || key_code == KEY_START)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign entry_digits = entry_q;
  assign load_value   = load_value_q;
  assign load_n       = load_n_q;
  assign start        = start_q;
  assign stop         = stop_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ms_time_entry.sv
// Directed bench for ms_time_entry: keypad sequences with hand-computed
// expected display, load, start, stop and error behaviour.
`timescale 1ns/1ps
module tb_ms_time_entry;

  logic        clk = 1'b0;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        timer_busy;
  logic        timer_zero;
  logic [15:0] entry_digits;
  logic [15:0] load_value;
  logic        load_n;
  logic        start;
  logic        stop;
  logic        err;

  int testsRun = 0;
  int failCount = 0;

  ms_time_entry dut (
    .clk          (clk),
    .clear        (clear),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .timer_busy   (timer_busy),
    .timer_zero   (timer_zero),
    .entry_digits (entry_digits),
    .load_value   (load_value),
    .load_n       (load_n),
    .start        (start),
    .stop         (stop),
    .err          (err)
  );

  always #5 clk = ~clk;

  // One keypress: key_valid high across exactly one rising edge. Returns on
  // the falling edge right after the press edge, where its effect is visible.
  task automatic applyStimulus(input logic [3:0] code);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic checkWord(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    clear      = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'd0;
    timer_busy = 1'b0;
    timer_zero = 1'b0;
    repeat (2) @(negedge clk);
    checkWord("reset entry", entry_digits, 16'h0000);
    checkWord("reset load_value", load_value, 16'h0000);
    checkOutput("reset load_n", load_n, 1'b1);
    checkOutput("reset start", start, 1'b0);
    checkOutput("reset stop", stop, 1'b0);
    checkOutput("reset err", err, 1'b0);
    clear = 1'b1;

    // 12:30 entered and loaded as-is
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd0);
    checkWord("entry 1230", entry_digits, 16'h1230);
    applyStimulus(4'd11);
    checkOutput("load_n low", load_n, 1'b0);
    checkWord("load_value 1230", load_value, 16'h1230);
    checkOutput("start not yet", start, 1'b0);
    @(negedge clk);
    checkOutput("load_n one cycle", load_n, 1'b1);
    checkOutput("start pulse", start, 1'b1);
    @(negedge clk);
    checkOutput("start one cycle", start, 1'b0);
    checkWord("entry held in run", entry_digits, 16'h1230);
    applyStimulus(4'd10);
    checkOutput("stop on cancel", stop, 1'b1);
    checkWord("entry cleared by cancel", entry_digits, 16'h0000);
    @(negedge clk);
    checkOutput("stop one cycle", stop, 1'b0);

    // 00:90 normalises to 01:30
    applyStimulus(4'd9);
    applyStimulus(4'd0);
    applyStimulus(4'd11);
    checkWord("normalise 0090", load_value, 16'h0130);
    repeat (2) @(negedge clk);
    applyStimulus(4'd10);

    // 99:75 saturates to 99:59
    applyStimulus(4'd9);
    applyStimulus(4'd9);
    applyStimulus(4'd7);
    applyStimulus(4'd5);
    applyStimulus(4'd11);
    checkWord("normalise 9975", load_value, 16'h9959);
    repeat (2) @(negedge clk);
    applyStimulus(4'd10);

    // Quick start, then timer reaching zero returns to IDLE
    applyStimulus(4'd11);
    checkWord("quick time", load_value, 16'h0030);
    checkOutput("quick load_n", load_n, 1'b0);
    repeat (2) @(negedge clk);
    timer_zero = 1'b1;
    repeat (2) @(negedge clk);
    timer_zero = 1'b0;
    checkWord("entry after zero", entry_digits, 16'h0000);
    applyStimulus(4'd7);
    checkWord("digit accepted after zero", entry_digits, 16'h0007);
    checkOutput("no err in idle", err, 1'b0);

    // Fifth digit rejected
    applyStimulus(4'd10);
    checkWord("cancel in entry", entry_digits, 16'h0000);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    applyStimulus(4'd5);
    checkOutput("err on fifth digit", err, 1'b1);
    checkWord("entry kept 1234", entry_digits, 16'h1234);
    @(negedge clk);
    checkOutput("err one cycle", err, 1'b0);

    // Held key_valid gives a single digit; ignored code 14 changes nothing
    applyStimulus(4'd10);
    applyStimulus(4'd14);
    checkOutput("code 14 no err", err, 1'b0);
    checkWord("code 14 no entry", entry_digits, 16'h0000);
    @(negedge clk);
    key_code  = 4'd6;
    key_valid = 1'b1;
    repeat (10) @(negedge clk);
    key_valid = 1'b0;
    checkWord("held key single digit", entry_digits, 16'h0006);

    // RUN: digit rejected, then CANCEL together with timer_zero
    applyStimulus(4'd11);
    checkWord("load_value 0006", load_value, 16'h0006);
    repeat (3) @(negedge clk);
    applyStimulus(4'd3);
    checkOutput("err digit in run", err, 1'b1);
    checkWord("entry unchanged in run", entry_digits, 16'h0006);
    @(negedge clk);
    key_code   = 4'd10;
    key_valid  = 1'b1;
    timer_zero = 1'b1;
    @(negedge clk);
    key_valid  = 1'b0;
    timer_zero = 1'b0;
    checkOutput("stop wins over zero", stop, 1'b1);
    checkWord("entry cleared on stop", entry_digits, 16'h0000);

    // START while timer busy is rejected
    timer_busy = 1'b1;
    applyStimulus(4'd11);
    checkOutput("err busy start", err, 1'b1);
    checkOutput("no load when busy", load_n, 1'b1);
    @(negedge clk);
    checkOutput("still no load when busy", load_n, 1'b1);
    timer_busy = 1'b0;

    // Asynchronous reset in the middle of LOAD
    applyStimulus(4'd4);
    applyStimulus(4'd2);
    applyStimulus(4'd11);
    checkOutput("load_n before clear", load_n, 1'b0);
    #2 clear = 1'b0;
    #1;
    checkOutput("async clear load_n", load_n, 1'b1);
    checkOutput("async clear start", start, 1'b0);
    checkWord("async clear entry", entry_digits, 16'h0000);
    checkWord("async clear load_value", load_value, 16'h0000);
    @(negedge clk);
    checkOutput("held clear start", start, 1'b0);
    clear = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
